// File: rtl/sram_serial_burst_ctrl.sv
// rtl/sram_serial_burst_ctrl.sv - serial host bridge to a single-port synchronous SRAM
// Frames arrive LSB first on SI; single/burst writes and reads, read data returned on SO.
module sram_serial_burst_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 9,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  BGN,
   input  logic                  SI,
   input  logic                  LOAD_N,
   input  logic [1:0]            CTRL,
   input  logic [DATA_WIDTH-1:0] PI,
   output logic                  RDY,
   output logic                  D_WE,
   output logic                  CEN,
   output logic                  SO,
   output logic                  SO_VLD,
   output logic [ADDR_WIDTH-1:0] A,
   output logic [DATA_WIDTH-1:0] PO
);

   localparam int DW = DATA_WIDTH;
   localparam int AW = ADDR_WIDTH;
   localparam int LW = LEN_WIDTH;
   localparam int SW = AW + ((DW > LW) ? DW : LW);
   localparam int CW = $clog2(SW);

   localparam logic [CW-1:0] LAST_SW = CW'(AW + DW - 1);
   localparam logic [CW-1:0] LAST_SR = CW'(AW - 1);
   localparam logic [CW-1:0] LAST_BR = CW'(AW + LW - 1);
   localparam logic [CW-1:0] LAST_WD = CW'(DW - 1);

   typedef enum logic [2:0] {IDLE, HDR, DAT, RD_REQ, RD_CAP, SHOUT, DONE} state_t;

   state_t          state_q;
   logic [1:0]      ctrl_q;
   logic [CW-1:0]   cnt_q;
   logic [SW-1:0]   sr_q, sr_d;
   logic [LW-1:0]   len_q;
   logic [DW-1:0]   osr_q, pf_q, po_q;
   logic [AW-1:0]   a_q;
   logic            cap_q, rdy_q, we_q, cen_q;
   logic [CW-1:0]   hdr_last;

   always_comb begin
      sr_d        = sr_q;
      sr_d[cnt_q] = SI;
   end

   always_comb begin
      hdr_last = LAST_BR;
      case (ctrl_q)
         2'b00:   hdr_last = LAST_SW;
         2'b01:   hdr_last = LAST_SR;
         default: hdr_last = LAST_BR;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= IDLE;
         ctrl_q  <= '0;
         cnt_q   <= '0;
         sr_q    <= '0;
         len_q   <= '0;
         osr_q   <= '0;
         pf_q    <= '0;
         po_q    <= '0;
         a_q     <= '0;
         cap_q   <= 1'b0;
         rdy_q   <= 1'b0;
         we_q    <= 1'b0;
         cen_q   <= 1'b0;
      end else begin
         // strobes are single-cycle pulses; PI is valid the cycle after a read access
         cen_q <= 1'b0;
         we_q  <= 1'b0;
         cap_q <= cen_q & ~we_q;
         if (cap_q) pf_q <= PI;
         case (state_q)
            IDLE: begin
               rdy_q <= 1'b0;
               cnt_q <= '0;
               osr_q <= '0;
               if (BGN) begin
                  ctrl_q  <= CTRL;
                  state_q <= HDR;
               end
            end
            HDR: begin
               if (!BGN) state_q <= IDLE;
               else if (!LOAD_N) begin
                  sr_q <= sr_d;
                  if (cnt_q == hdr_last) begin
                     cnt_q <= '0;
                     case (ctrl_q)
                        2'b00: begin
                           cen_q   <= 1'b1;
                           we_q    <= 1'b1;
                           a_q     <= sr_d[DW+AW-1:DW];
                           po_q    <= sr_d[DW-1:0];
                           state_q <= DONE;
                        end
                        2'b01: begin
                           cen_q   <= 1'b1;
                           a_q     <= sr_d[AW-1:0];
                           len_q   <= '0;
                           state_q <= RD_REQ;
                        end
                        2'b10: begin
                           a_q     <= sr_d[AW-1:0];
                           len_q   <= sr_d[AW+LW-1:AW];
                           state_q <= DAT;
                        end
                        default: begin
                           cen_q   <= 1'b1;
                           a_q     <= sr_d[AW-1:0];
                           len_q   <= sr_d[AW+LW-1:AW];
                           state_q <= RD_REQ;
                        end
                     endcase
                  end else cnt_q <= cnt_q + 1'b1;
               end
            end
            DAT: begin
               if (!BGN) state_q <= IDLE;
               else begin
                  if (we_q) a_q <= a_q + 1'b1;
                  if (!LOAD_N) begin
                     sr_q <= sr_d;
                     if (cnt_q == LAST_WD) begin
                        cnt_q <= '0;
                        cen_q <= 1'b1;
                        we_q  <= 1'b1;
                        po_q  <= sr_d[DW-1:0];
                        if (len_q == '0) state_q <= DONE;
                        else len_q <= len_q - 1'b1;
                     end else cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            RD_REQ: state_q <= BGN ? RD_CAP : IDLE;
            RD_CAP: begin
               if (!BGN) state_q <= IDLE;
               else begin
                  osr_q   <= PI;
                  cnt_q   <= '0;
                  state_q <= SHOUT;
                  if (len_q != '0) begin
                     cen_q <= 1'b1;
                     a_q   <= a_q + 1'b1;
                  end
               end
            end
            SHOUT: begin
               if (!BGN) state_q <= IDLE;
               else if (!LOAD_N) begin
                  if (cnt_q == LAST_WD) begin
                     cnt_q <= '0;
                     if (len_q == '0) begin
                        osr_q   <= {1'b0, osr_q[DW-1:1]};
                        rdy_q   <= 1'b1;
                        state_q <= DONE;
                     end else begin
                        osr_q <= pf_q;
                        len_q <= len_q - 1'b1;
                        if (len_q != LW'(1)) begin
                           cen_q <= 1'b1;
                           a_q   <= a_q + 1'b1;
                        end
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                     osr_q <= {1'b0, osr_q[DW-1:1]};
                  end
               end
            end
            DONE: begin
               if (!BGN) begin
                  rdy_q   <= 1'b0;
                  state_q <= IDLE;
               end else rdy_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign RDY    = rdy_q;
   assign D_WE   = we_q;
   assign CEN    = cen_q;
   assign A      = a_q;
   assign PO     = po_q;
   assign SO     = osr_q[0];
   assign SO_VLD = (state_q == SHOUT) && BGN && !LOAD_N;

endmodule

// File: tb/tb_sram_serial_burst_ctrl.sv
// tb/tb_sram_serial_burst_ctrl.sv - directed bench for sram_serial_burst_ctrl with a behavioural SRAM
module tb_sram_serial_burst_ctrl;

   logic       CLK, RST_N, BGN, SI, LOAD_N;
   logic [1:0] CTRL;
   logic [7:0] PI;
   logic       RDY, D_WE, CEN, SO, SO_VLD;
   logic [8:0] A;
   logic [7:0] PO;

   logic [7:0] mem [0:511];
   logic [7:0] q;
   logic       poke_en;
   logic [8:0] poke_a;
   logic [7:0] poke_d;
   int         wr_cnt = 0;
   int         rd_cnt = 0;
   int         bad_cnt = 0;
   int         checks = 0;
   int         errors = 0;
   int         wr0, rd0;
   logic [15:0] stream;

   sram_serial_burst_ctrl dut (
      .CLK(CLK), .RST_N(RST_N), .BGN(BGN), .SI(SI), .LOAD_N(LOAD_N), .CTRL(CTRL),
      .PI(PI), .RDY(RDY), .D_WE(D_WE), .CEN(CEN), .SO(SO), .SO_VLD(SO_VLD),
      .A(A), .PO(PO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   assign PI = q;

   always @(posedge CLK) begin
      if (poke_en) mem[poke_a] <= poke_d;
      else if (CEN && D_WE) mem[A] <= PO;
      if (CEN && !D_WE) q <= mem[A];
      if (RST_N) begin
         if (CEN && D_WE)  wr_cnt  <= wr_cnt + 1;
         if (CEN && !D_WE) rd_cnt  <= rd_cnt + 1;
         if (D_WE && !CEN) bad_cnt <= bad_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         SI     = v[i];
         LOAD_N = 1'b0;
         tick();
      end
   endtask

   task automatic poke(input logic [8:0] a, input logic [7:0] d);
      poke_en = 1'b1;
      poke_a  = a;
      poke_d  = d;
      tick();
      poke_en = 1'b0;
   endtask

   task automatic start(input logic [1:0] c);
      BGN    = 1'b1;
      CTRL   = c;
      LOAD_N = 1'b1;
      tick();
   endtask

   task automatic finish_txn();
      LOAD_N = 1'b1;
      BGN    = 1'b0;
      tick();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rdy"}, 32'(RDY), 32'd0);
      chk({tag, "_we"}, 32'(D_WE), 32'd0);
      chk({tag, "_cen"}, 32'(CEN), 32'd0);
      chk({tag, "_so"}, 32'(SO), 32'd0);
      chk({tag, "_sovld"}, 32'(SO_VLD), 32'd0);
      chk({tag, "_a"}, 32'(A), 32'd0);
      chk({tag, "_po"}, 32'(PO), 32'd0);
   endtask

   task automatic chk_write(input string tag, input logic [8:0] a, input logic [7:0] d);
      chk({tag, "_cen"}, 32'(CEN), 32'd1);
      chk({tag, "_we"}, 32'(D_WE), 32'd1);
      chk({tag, "_a"}, 32'(A), 32'(a));
      chk({tag, "_po"}, 32'(PO), 32'(d));
   endtask

   initial begin
      RST_N = 1'b0; BGN = 1'b0; SI = 1'b0; LOAD_N = 1'b1; CTRL = 2'b00;
      poke_en = 1'b0; poke_a = '0; poke_d = '0; q = '0;
      repeat (3) tick();
      chk_reset_outputs("reset");
      RST_N = 1'b1;
      tick();

      // single write {0x020, 0xAB}
      wr0 = wr_cnt;
      start(2'b00);
      send_bits(32'({9'h020, 8'hAB}), 17);
      chk_write("sw", 9'h020, 8'hAB);
      chk("sw_rdy_n1", 32'(RDY), 32'd0);
      LOAD_N = 1'b1;
      tick();
      chk("sw_rdy_n2", 32'(RDY), 32'd1);
      chk("sw_cen_n2", 32'(CEN), 32'd0);
      finish_txn();
      chk("sw_rdy_drop", 32'(RDY), 32'd0);
      chk("sw_wr_count", 32'(wr_cnt - wr0), 32'd1);
      chk("sw_mem", 32'(mem[9'h020]), 32'hAB);

      // single read of 0x021 holding 0x3C
      poke(9'h021, 8'h3C);
      rd0 = rd_cnt;
      start(2'b01);
      send_bits(32'(9'h021), 9);
      chk("sr_req_cen", 32'(CEN), 32'd1);
      chk("sr_req_we", 32'(D_WE), 32'd0);
      chk("sr_req_a", 32'(A), 32'h021);
      tick();
      chk("sr_cap_vld", 32'(SO_VLD), 32'd0);
      tick();
      stream = 16'h003C;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("sr_vld%0d", i), 32'(SO_VLD), 32'd1);
         chk($sformatf("sr_so%0d", i), 32'(SO), 32'(stream[i]));
         tick();
      end
      #1;
      chk("sr_rdy", 32'(RDY), 32'd1);
      chk("sr_vld_end", 32'(SO_VLD), 32'd0);
      finish_txn();
      chk("sr_rd_count", 32'(rd_cnt - rd0), 32'd1);

      // burst write with wrap: 0x1FE..0x000
      wr0 = wr_cnt;
      start(2'b10);
      send_bits(32'({4'd2, 9'h1FE}), 13);
      send_bits(32'h11, 8);
      chk_write("bw0", 9'h1FE, 8'h11);
      send_bits(32'h22, 8);
      chk_write("bw1", 9'h1FF, 8'h22);
      send_bits(32'h33, 8);
      chk_write("bw2", 9'h000, 8'h33);
      LOAD_N = 1'b1;
      tick();
      chk("bw_rdy", 32'(RDY), 32'd1);
      finish_txn();
      chk("bw_wr_count", 32'(wr_cnt - wr0), 32'd3);
      chk("bw_mem0", 32'(mem[9'h1FE]), 32'h11);
      chk("bw_mem1", 32'(mem[9'h1FF]), 32'h22);
      chk("bw_mem2", 32'(mem[9'h000]), 32'h33);

      // burst read of 0x020/0x021 with a 3-cycle stall mid-word
      rd0 = rd_cnt;
      start(2'b11);
      send_bits(32'({4'd1, 9'h020}), 13);
      chk("br_req_cen", 32'(CEN), 32'd1);
      chk("br_req_a", 32'(A), 32'h020);
      tick();
      tick();
      chk("br_pf_cen", 32'(CEN), 32'd1);
      chk("br_pf_a", 32'(A), 32'h021);
      stream = {8'h3C, 8'hAB};
      for (int i = 0; i < 16; i++) begin
         if (i == 4) begin
            LOAD_N = 1'b1;
            for (int s = 0; s < 3; s++) begin
               #1;
               chk($sformatf("br_stall_vld%0d", s), 32'(SO_VLD), 32'd0);
               chk($sformatf("br_stall_so%0d", s), 32'(SO), 32'(stream[4]));
               tick();
            end
            LOAD_N = 1'b0;
         end
         #1;
         chk($sformatf("br_vld%0d", i), 32'(SO_VLD), 32'd1);
         chk($sformatf("br_so%0d", i), 32'(SO), 32'(stream[i]));
         tick();
      end
      #1;
      chk("br_rdy", 32'(RDY), 32'd1);
      finish_txn();
      chk("br_rd_count", 32'(rd_cnt - rd0), 32'd2);

      // abort after 10 bits, then abort on the final bit, then a clean write
      wr0 = wr_cnt;
      rd0 = rd_cnt;
      start(2'b00);
      send_bits(32'({9'h030, 8'h5A}), 10);
      finish_txn();
      chk("ab_cen", 32'(CEN), 32'd0);
      chk("ab_rdy", 32'(RDY), 32'd0);
      tick();
      start(2'b00);
      send_bits(32'({9'h030, 8'h5A}), 16);
      BGN    = 1'b0;
      SI     = 1'b0;
      LOAD_N = 1'b0;
      tick();
      chk("ab_last_cen", 32'(CEN), 32'd0);
      tick();
      chk("ab_no_access", 32'((wr_cnt - wr0) + (rd_cnt - rd0)), 32'd0);
      chk("ab_rdy2", 32'(RDY), 32'd0);
      start(2'b00);
      send_bits(32'({9'h030, 8'h5A}), 17);
      chk_write("ab_retry", 9'h030, 8'h5A);
      LOAD_N = 1'b1;
      tick();
      chk("ab_retry_rdy", 32'(RDY), 32'd1);
      finish_txn();
      chk("ab_mem", 32'(mem[9'h030]), 32'h5A);

      // reset during the second word of a burst write
      poke(9'h041, 8'h00);
      start(2'b10);
      send_bits(32'({4'd1, 9'h040}), 13);
      send_bits(32'h77, 8);
      chk_write("rs_w0", 9'h040, 8'h77);
      send_bits(32'h88, 3);
      RST_N = 1'b0;
      tick();
      chk_reset_outputs("rs");
      RST_N  = 1'b1;
      BGN    = 1'b0;
      LOAD_N = 1'b1;
      tick();
      chk("rs_mem0", 32'(mem[9'h040]), 32'h77);
      chk("rs_mem1", 32'(mem[9'h041]), 32'h00);
      start(2'b00);
      send_bits(32'({9'h041, 8'h99}), 17);
      chk_write("rs_fresh", 9'h041, 8'h99);
      LOAD_N = 1'b1;
      tick();
      chk("rs_fresh_rdy", 32'(RDY), 32'd1);
      finish_txn();
      chk("we_without_cen", 32'(bad_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
